serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 128 ++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks the operands MSB-first, one
// 2-bit digit pair per clock, folding each pair into registered cascade flags.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             a_greater,
  output logic             a_less
);

  localparam int NDIG  = WIDTH / 2;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             equal_q, equal_d, greater_q, greater_d, less_q, less_d;
  logic [1:0]       a_dig, b_dig;

  // Operands shift left each step, so the current digit is always the top pair.
  assign a_dig = a_q[WIDTH-1 -: 2];
  assign b_dig = b_q[WIDTH-1 -: 2];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    equal_d   = equal_q;
    greater_d = greater_q;
    less_d    = less_q;
    case (state_q)
      S_RUN: begin
        if (eq_q) begin
          if (a_dig > b_dig) begin
            gt_d = 1'b1;
            eq_d = 1'b0;
          end else if (a_dig < b_dig) begin
            lt_d = 1'b1;
            eq_d = 1'b0;
          end
        end
        a_d   = a_q << 2;
        b_d   = b_q << 2;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          equal_d   = eq_d;
          greater_d = gt_d;
          less_d    = lt_d;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE lasts one cycle.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MAX;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= IDX_MAX;
      eq_q      <= 1'b1;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
      less_q    <= less_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign equal     = equal_q;
  assign a_greater = greater_q;
  assign a_less    = less_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomized checks of the serial comparator at WIDTH=8 and WIDTH=2.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, busy8, done8, eq8, gt8, lt8;
  logic [7:0] a8, b8;
  logic       start2, busy2, done2, eq2, gt2, lt2;
  logic [1:0] a2, b2;
  logic [4:0] obs8, obs2;

  int total = 0;
  int bad   = 0;

  // Observation vectors are {busy, done, equal, a_greater, a_less}.
  assign obs8 = {busy8, done8, eq8, gt8, lt8};
  assign obs2 = {busy2, done2, eq2, gt2, lt2};

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .equal(eq8), .a_greater(gt8), .a_less(lt8)
  );

  serial_magnitude_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .equal(eq2), .a_greater(gt2), .a_less(lt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch8(input logic [7:0] av, input logic [7:0] bv);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (3) tick();
    total++;
    if (obs8 !== 5'b00000) begin bad++; $display("FAIL reset_w8 got=%b want=%b", obs8, 5'b00000); end
    total++;
    if (obs2 !== 5'b00000) begin bad++; $display("FAIL reset_w2 got=%b want=%b", obs2, 5'b00000); end
    rst = 1'b0;
    tick();
    total++;
    if (obs8 !== 5'b00000) begin bad++; $display("FAIL idle_after_reset got=%b want=%b", obs8, 5'b00000); end
  endtask

  task automatic test_equal;
    logic [4:0] exp;
    launch8(8'h5A, 8'h5A);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10000 : (k == 4) ? 5'b01100 : 5'b00100;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL equal_5A k=%0d got=%b want=%b", k, obs8, exp); end
    end
  endtask

  task automatic test_first_last;
    logic [4:0] exp;
    launch8(8'h80, 8'h7F);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10100 : (k == 4) ? 5'b01010 : 5'b00010;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL first_digit k=%0d got=%b want=%b", k, obs8, exp); end
    end
    launch8(8'h03, 8'h04);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10010 : (k == 4) ? 5'b01001 : 5'b00001;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL last_digit k=%0d got=%b want=%b", k, obs8, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    launch8(8'hFF, 8'h00);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10001 : 5'b01010;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL b2b_first k=%0d got=%b want=%b", k, obs8, exp); end
    end
    // Request presented while DONE is showing; must be taken with no bubble.
    launch8(8'h00, 8'hFF);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10010 : 5'b01001;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL b2b_second k=%0d got=%b want=%b", k, obs8, exp); end
    end
    tick();
  endtask

  task automatic test_start_during_run;
    logic [4:0] exp;
    launch8(8'h20, 8'h10);
    tick();
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      if (k > 2) tick();
      exp = (k < 4) ? 5'b10001 : (k == 4) ? 5'b01010 : 5'b00010;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL start_in_run k=%0d got=%b want=%b", k, obs8, exp); end
    end
  endtask

  task automatic test_mid_run_reset;
    logic [4:0] exp;
    launch8(8'h11, 8'h22);
    tick();
    total++;
    if (obs8 !== 5'b10010) begin bad++; $display("FAIL pre_reset got=%b want=%b", obs8, 5'b10010); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      total++;
      if (obs8 !== 5'b00000) begin bad++; $display("FAIL mid_reset k=%0d got=%b want=%b", k, obs8, 5'b00000); end
    end
    launch8(8'h44, 8'h33);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? 5'b10000 : 5'b01010;
      total++;
      if (obs8 !== exp) begin bad++; $display("FAIL after_reset k=%0d got=%b want=%b", k, obs8, exp); end
    end
    tick();
  endtask

  task automatic test_random;
    logic [2:0] exp8, exp2;
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(3) == 0) ? a8 : 8'($urandom);
      a2 = 2'($urandom);
      b2 = ($urandom_range(3) == 0) ? a2 : 2'($urandom);
      exp8 = {a8 == b8, a8 > b8, a8 < b8};
      exp2 = {a2 == b2, a2 > b2, a2 < b2};
      start8 = 1'b1; start2 = 1'b1;
      tick();
      start8 = 1'b0; start2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        tick();
        total++;
        if (done8 !== (k == 4)) begin bad++; $display("FAIL rnd_done_w8 n=%0d k=%0d got=%b want=%b", n, k, done8, (k == 4)); end
        total++;
        if (done2 !== (k == 1)) begin bad++; $display("FAIL rnd_done_w2 n=%0d k=%0d got=%b want=%b", n, k, done2, (k == 1)); end
        if (k == 4) begin
          total++;
          if ({eq8, gt8, lt8} !== exp8 || $countones({eq8, gt8, lt8}) != 1) begin
            bad++; $display("FAIL rnd_w8 a=%h b=%h got=%b want=%b", a8, b8, {eq8, gt8, lt8}, exp8);
          end
        end
        if (k == 1) begin
          total++;
          if ({eq2, gt2, lt2} !== exp2 || $countones({eq2, gt2, lt2}) != 1) begin
            bad++; $display("FAIL rnd_w2 a=%h b=%h got=%b want=%b", a2, b2, {eq2, gt2, lt2}, exp2);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_first_last();
    test_back_to_back();
    test_start_during_run();
    test_mid_run_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
